// File: rtl/scheduler_task_type_lookup_pkg.sv
// Shared scheduling-data layout and lookup FSM encoding.
// Used by the bitinfo writer and the task-type lookup reader.
package OmpSsManager;

  localparam int SCHED_DATA_W           = 50;
  localparam int SCHED_DATA_ACCID_L     = 0;
  localparam int SCHED_DATA_COUNT_L     = 8;
  localparam int SCHED_DATA_TASK_TYPE_L = 16;
  localparam int SCHED_DATA_TASK_TYPE_H = 49;
  localparam int TASK_TYPE_W =
    SCHED_DATA_TASK_TYPE_H - SCHED_DATA_TASK_TYPE_L + 1;

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_ISSUE,
    LK_COMPARE,
    LK_RESPOND
  } sched_lookup_state_t;

endpackage

// File: rtl/scheduler_rr_table.sv
// Per-entry round-robin offsets for the task-type lookup.
// Combinational read port, wrapping increment write port.
module scheduler_rr_table #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] rd_idx,
  output logic [W-1:0] rd_val,
  input  logic         wr_en,
  input  logic [W-1:0] wr_idx,
  input  logic [W-1:0] wr_count
);

  logic [W-1:0] rr [N];

  assign rd_val = rr[rd_idx];

  // Advance the selected offset, wrapping back to 0 after count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) rr[i] <= '0;
    end else if (wr_en) begin
      if (rr[wr_idx] == wr_count) rr[wr_idx] <= '0;
      else rr[wr_idx] <= rr[wr_idx] + 1'b1;
    end
  end

endmodule

// File: rtl/scheduler_task_type_lookup.sv
// Task type -> accelerator id lookup over the scheduling memory.
// Optional last-hit cache: define SCHED_LOOKUP_LAST_HIT_EN.
module scheduler_task_type_lookup
  import OmpSsManager::*;
#(
  parameter int MAX_ACCS = 16,
  localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sched_data_valid,
  input  logic [ACC_BITS:0]       num_entries,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TASK_TYPE_W-1:0]  req_task_type,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_found,
  output logic [ACC_BITS-1:0]     rsp_accid,
  output logic [ACC_BITS-1:0]     scheduleData_portB_addr,
  output logic                    scheduleData_portB_en,
  input  logic [SCHED_DATA_W-1:0] scheduleData_portB_dout
);

  sched_lookup_state_t state;

  logic [TASK_TYPE_W-1:0] typ_q;
  logic [ACC_BITS:0]      n_q;
  logic [ACC_BITS-1:0]    idx;
  logic [ACC_BITS-1:0]    cnt_q;

  logic [TASK_TYPE_W-1:0] d_type;
  logic [ACC_BITS-1:0]    d_base;
  logic [ACC_BITS-1:0]    d_cnt;
  logic                   match;
  logic                   last;

  logic [ACC_BITS-1:0]    rr_idx;
  logic [ACC_BITS-1:0]    rr_val;
  logic                   rr_we;

  logic                   c_hit;
  logic [ACC_BITS-1:0]    c_idx;
  logic [ACC_BITS-1:0]    c_base;
  logic [ACC_BITS-1:0]    c_cnt;

  logic                   unused_dout;

  assign d_type = scheduleData_portB_dout[
    SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
  assign d_base = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
  assign d_cnt  = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
  assign unused_dout = ^scheduleData_portB_dout;

  assign match = (d_type == typ_q);
  assign last  = ({1'b0, idx} == n_q - 1'b1);

  assign req_ready = (state == LK_IDLE) && sched_data_valid;

  assign rr_idx = (state == LK_IDLE) ? c_idx : idx;
  assign rr_we  = (state == LK_RESPOND) && rsp_ready && rsp_found;

  scheduler_rr_table #(
    .N (MAX_ACCS),
    .W (ACC_BITS)
  ) u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .rd_idx   (rr_idx),
    .rd_val   (rr_val),
    .wr_en    (rr_we),
    .wr_idx   (idx),
    .wr_count (cnt_q)
  );

`ifdef SCHED_LOOKUP_LAST_HIT_EN
  logic                   c_vld;
  logic [TASK_TYPE_W-1:0] c_type;

  assign c_hit = c_vld && (c_type == req_task_type);

  // Remember the last scanned hit; drop it while memory is unstable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_vld  <= 1'b0;
      c_type <= '0;
      c_idx  <= '0;
      c_base <= '0;
      c_cnt  <= '0;
    end else if (!sched_data_valid) begin
      c_vld <= 1'b0;
    end else if (state == LK_COMPARE && match) begin
      c_vld  <= 1'b1;
      c_type <= typ_q;
      c_idx  <= idx;
      c_base <= d_base;
      c_cnt  <= d_cnt;
    end
  end
`else
  assign c_hit  = 1'b0;
  assign c_idx  = '0;
  assign c_base = '0;
  assign c_cnt  = '0;
`endif

  // Lookup FSM: accept, scan entries two cycles each, respond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                   <= LK_IDLE;
      typ_q                   <= '0;
      n_q                     <= '0;
      idx                     <= '0;
      cnt_q                   <= '0;
      rsp_valid               <= 1'b0;
      rsp_found               <= 1'b0;
      rsp_accid               <= '0;
      scheduleData_portB_en   <= 1'b0;
      scheduleData_portB_addr <= '0;
    end else begin
      unique case (state)
        LK_IDLE: begin
          if (req_valid && sched_data_valid) begin
            typ_q <= req_task_type;
            n_q   <= num_entries;
            idx   <= '0;
            if (c_hit) begin
              idx       <= c_idx;
              cnt_q     <= c_cnt;
              rsp_found <= 1'b1;
              rsp_accid <= c_base + rr_val;
              rsp_valid <= 1'b1;
              state     <= LK_RESPOND;
            end else if (num_entries == '0) begin
              rsp_found <= 1'b0;
              rsp_accid <= '0;
              rsp_valid <= 1'b1;
              state     <= LK_RESPOND;
            end else begin
              scheduleData_portB_en   <= 1'b1;
              scheduleData_portB_addr <= '0;
              state                   <= LK_ISSUE;
            end
          end
        end
        LK_ISSUE: begin
          scheduleData_portB_en <= 1'b0;
          state                 <= LK_COMPARE;
        end
        LK_COMPARE: begin
          if (match) begin
            cnt_q     <= d_cnt;
            rsp_found <= 1'b1;
            rsp_accid <= d_base + rr_val;
            rsp_valid <= 1'b1;
            state     <= LK_RESPOND;
          end else if (last) begin
            rsp_found <= 1'b0;
            rsp_accid <= '0;
            rsp_valid <= 1'b1;
            state     <= LK_RESPOND;
          end else begin
            idx                     <= idx + 1'b1;
            scheduleData_portB_addr <= idx + 1'b1;
            scheduleData_portB_en   <= 1'b1;
            state                   <= LK_ISSUE;
          end
        end
        LK_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= LK_IDLE;
          end
        end
        default: state <= LK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scheduler_task_type_lookup.sv
// Scoreboard bench for scheduler_task_type_lookup.
// Reference model tracks table, round-robin offsets and last-hit cache.
module tb_scheduler_task_type_lookup;

  localparam int NA = 16;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sched_data_valid = 1'b0;
  logic [AB:0]   num_entries = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [33:0]   req_task_type = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_found;
  logic [AB-1:0] rsp_accid;
  logic [AB-1:0] mem_addr;
  logic          mem_en;
  logic [49:0]   mem_dout = '0;

  always #5 clk = ~clk;

  scheduler_task_type_lookup #(.MAX_ACCS(NA)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .sched_data_valid        (sched_data_valid),
    .num_entries             (num_entries),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_task_type           (req_task_type),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_found               (rsp_found),
    .rsp_accid               (rsp_accid),
    .scheduleData_portB_addr (mem_addr),
    .scheduleData_portB_en   (mem_en),
    .scheduleData_portB_dout (mem_dout)
  );

  logic [49:0] mem [NA];

  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

  typedef struct {
    bit found;
    int accid;
    int lat;
    int ens;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int en_cnt = 0;

  int m_type [NA];
  int m_base [NA];
  int m_cnt  [NA];
  int m_rr   [NA];
  int cur_n = 0;
  bit c_v = 0;
  int c_type = 0;
  int c_idx = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) begin
      acc_cyc <= cyc;
      en_cnt  <= 0;
    end else if (mem_en) begin
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int t);
    exp_t e;
    int hit;
    e.found = 0;
    e.accid = 0;
    e.lat   = 2 * cur_n + 1;
    e.ens   = cur_n;
    hit     = -1;
`ifdef SCHED_LOOKUP_LAST_HIT_EN
    if (c_v && c_type == t) begin
      hit   = c_idx;
      e.lat = 1;
      e.ens = 0;
    end
`endif
    if (hit < 0) begin
      for (int i = 0; i < cur_n; i++) begin
        if (m_type[i] == t) begin
          hit   = i;
          e.lat = 2 * i + 3;
          e.ens = i + 1;
          break;
        end
      end
    end
    if (hit >= 0) begin
      e.found = 1;
      e.accid = (m_base[hit] + m_rr[hit]) % NA;
      m_rr[hit] = (m_rr[hit] == m_cnt[hit]) ? 0 : m_rr[hit] + 1;
      c_v    = 1;
      c_type = t;
      c_idx  = hit;
    end
    return e;
  endfunction

  // Monitor: check each new response, then its stability while held.
  initial begin
    bit   seen;
    exp_t cur;
    seen = 0;
    cur  = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        seen = 0;
      end else if (rsp_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            cur = q.pop_front();
            chk("rsp_found", int'(rsp_found), int'(cur.found));
            chk("rsp_accid", int'(rsp_accid), cur.accid);
            chk("rsp_latency", cyc - acc_cyc, cur.lat);
            chk("mem_reads", en_cnt, cur.ens);
          end
          seen = 1;
        end else begin
          chk("hold_found", int'(rsp_found), int'(cur.found));
          chk("hold_accid", int'(rsp_accid), cur.accid);
        end
      end else begin
        seen = 0;
      end
    end
  end

  task automatic write_mem();
    for (int i = 0; i < NA; i++) begin
      logic [49:0] w;
      w = '0;
      w[49:16] = 34'(m_type[i]);
      w[15:8]  = 8'(m_cnt[i]);
      w[7:0]   = 8'(m_base[i]);
      mem[i]   = w;
    end
  endtask

  task automatic drop_sdv();
    @(negedge clk);
    sched_data_valid = 1'b0;
    c_v = 0;
    @(negedge clk);
    sched_data_valid = 1'b1;
  endtask

  task automatic set_table(int n);
    @(negedge clk);
    sched_data_valid = 1'b0;
    c_v = 0;
    write_mem();
    cur_n = n;
    num_entries = (AB+1)'(n);
    @(negedge clk);
    sched_data_valid = 1'b1;
  endtask

  task automatic do_req(int t, int hold);
    int   w;
    exp_t e;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    e = model(t);
    q.push_back(e);
    req_valid = 1'b1;
    req_task_type = 34'(t);
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_timeout", 0, 1);
      rsp_ready = 1'b0;
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        chk("req_ready_during_hold", int'(req_ready), 0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NA; i++) begin
      m_type[i] = 300;
      m_base[i] = 5;
      m_cnt[i]  = 0;
      m_rr[i]   = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_found", int'(rsp_found), 0);
    chk("reset_rsp_accid", int'(rsp_accid), 0);
    chk("reset_en", int'(mem_en), 0);
    chk("reset_addr", int'(mem_addr), 0);
    rstn = 1'b1;

    m_type[0] = 100; m_base[0] = 0; m_cnt[0] = 1;
    m_type[1] = 200; m_base[1] = 2; m_cnt[1] = 0;
    set_table(2);
    do_req(200, 0);
    do_req(100, 0);
    do_req(100, 0);
    do_req(100, 0);
    do_req(300, 2);
    do_req(200, 0);
    do_req(200, 0);
    drop_sdv();
    do_req(200, 0);

    set_table(0);
    do_req(100, 0);
    set_table(2);
    do_req(100, 10);
    do_req(100, 0);

    // Reset during a scan must clear outputs and offsets at once.
    @(negedge clk);
    req_valid = 1'b1;
    req_task_type = 34'd300;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset_rsp_valid", int'(rsp_valid), 0);
    chk("midreset_rsp_found", int'(rsp_found), 0);
    chk("midreset_rsp_accid", int'(rsp_accid), 0);
    chk("midreset_en", int'(mem_en), 0);
    chk("midreset_addr", int'(mem_addr), 0);
    q.delete();
    for (int i = 0; i < NA; i++) m_rr[i] = 0;
    c_v = 0;
    @(negedge clk);
    rstn = 1'b1;
    do_req(100, 0);

    for (int tbl = 0; tbl < 8; tbl++) begin
      for (int i = 0; i < NA; i++) begin
        m_type[i] = $urandom_range(1, 6);
        m_base[i] = $urandom_range(0, 15);
        m_cnt[i]  = $urandom_range(0, 3);
        m_rr[i]   = (m_rr[i] > m_cnt[i]) ? m_rr[i] : m_rr[i];
      end
      for (int i = 0; i < NA; i++) m_rr[i] = m_rr[i];
      set_table($urandom_range(0, NA));
      for (int r = 0; r < 8; r++) begin
        do_req($urandom_range(0, 7), $urandom_range(0, 3));
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
